// File: rtl/alu_cmd_sequencer.sv
// Byte-stream front end for the 8-bit ALU: opcode/A/B frame in, result/flags bytes out.
// Latency: B handshake to out_valid is SETTLE_CYCLES+1 cycles; input stalls (in_ready=0) from execute until the flags byte leaves.
module alu_cmd_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_result,
  input  logic       alu_cout,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       err
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  typedef enum logic [2:0] {S_OP, S_A, S_B, S_EXEC, S_RES, S_FLG} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [7:0] res_q;
  logic       cout_q;
  logic       zero_q;
  logic       in_hs;
  logic       out_hs;
  logic       op_legal;
  logic       settle_done;

  assign in_hs       = in_valid && in_ready;
  assign out_hs      = out_valid && out_ready;
  assign op_legal    = (in_data[7:3] == 5'd0);
  assign settle_done = (cnt <= 4'd1);
  assign busy        = (state != S_OP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_OP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (state)
      S_OP: begin
        in_ready = 1'b1;
        if (in_hs && op_legal) state_nxt = S_A;
      end
      S_A: begin
        in_ready = 1'b1;
        if (in_hs) state_nxt = S_B;
      end
      S_B: begin
        in_ready = 1'b1;
        if (in_hs) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (settle_done) state_nxt = S_RES;
      end
      S_RES: begin
        out_valid = 1'b1;
        out_data  = res_q;
        if (out_hs) state_nxt = S_FLG;
      end
      S_FLG: begin
        out_valid = 1'b1;
        out_data  = {6'b0, zero_q, cout_q};
        if (out_hs) state_nxt = S_OP;
      end
      default: state_nxt = S_OP;
    endcase
  end

  // Operand registers only move on an accepted byte, so they hold between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a   <= 8'h00;
      alu_b   <= 8'h00;
      alu_sel <= 3'd0;
      cnt     <= 4'd0;
      res_q   <= 8'h00;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_OP: begin
          if (in_hs) begin
            if (op_legal) alu_sel <= in_data[2:0];
            else          err     <= 1'b1;
          end
        end
        S_A: begin
          if (in_hs) alu_a <= in_data;
        end
        S_B: begin
          if (in_hs) begin
            alu_b <= in_data;
            cnt   <= SETTLE_LD;
          end
        end
        S_EXEC: begin
          cnt <= cnt - 4'd1;
          if (settle_done) begin
            res_q  <= alu_result;
            cout_q <= alu_cout;
            zero_q <= (alu_result == 8'h00);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed-vector bench for alu_cmd_sequencer with a behavioural ALU attached.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, busy, err, alu_cout;
  logic [7:0] alu_a, alu_b, alu_result, out_data;
  logic [2:0] alu_sel;

  logic       in_valid15 = 1'b0;
  logic       out_ready15 = 1'b1;
  logic       in_ready15, out_valid15, busy15, err15, alu_cout15;
  logic [7:0] alu_a15, alu_b15, alu_result15, out_data15;
  logic [2:0] alu_sel15;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [8:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} + {1'b0, ~b} + 9'd1;
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      default: return 9'd0;
    endcase
  endfunction

  assign {alu_cout, alu_result}     = alu_f(alu_sel, alu_a, alu_b);
  assign {alu_cout15, alu_result15} = alu_f(alu_sel15, alu_a15, alu_b15);

  alu_cmd_sequencer #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result), .alu_cout(alu_cout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err)
  );

  alu_cmd_sequencer #(.SETTLE_CYCLES(15)) dut15 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid15), .in_ready(in_ready15),
    .alu_a(alu_a15), .alu_b(alu_b15), .alu_sel(alu_sel15), .alu_result(alu_result15), .alu_cout(alu_cout15),
    .out_data(out_data15), .out_valid(out_valid15), .out_ready(out_ready15), .busy(busy15), .err(err15)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge right after the handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b, input int gap);
    send_byte(op);
    repeat (gap) @(negedge clk);
    send_byte(a);
    repeat (gap) @(negedge clk);
    send_byte(b);
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat <= 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic recv(output logic [7:0] r, output logic [7:0] f);
    int t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("recv_timeout", 1, 0);
    r = out_data;
    @(negedge clk);
    chk("flags_valid", out_valid, 1);
    f = out_data;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] op, a, b, res, flg;
  } vec_t;

  vec_t       vecs[8];
  int         lat;
  logic [7:0] r, f;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h00, 8'hC8, 8'h64, 8'h2C, 8'h01};
    vecs[1] = '{8'h01, 8'h05, 8'h07, 8'hFE, 8'h00};
    vecs[2] = '{8'h02, 8'hF0, 8'h0F, 8'h00, 8'h02};
    vecs[3] = '{8'h03, 8'hA0, 8'h05, 8'hA5, 8'h00};
    vecs[4] = '{8'h05, 8'h12, 8'h34, 8'h00, 8'h02};
    vecs[5] = '{8'h00, 8'hFF, 8'h01, 8'h00, 8'h03};
    vecs[6] = '{8'h01, 8'h07, 8'h05, 8'h02, 8'h01};
    vecs[7] = '{8'h07, 8'h55, 8'hAA, 8'h00, 8'h02};

    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].op, vecs[i].a, vecs[i].b, (i >= 4) ? int'($urandom_range(0, 3)) : 0);
      chk($sformatf("v%0d_busy_exec", i), busy, 1);
      chk($sformatf("v%0d_in_ready_exec", i), in_ready, 0);
      wait_out(lat);
      chk($sformatf("v%0d_latency", i), lat, 2);
      recv(r, f);
      chk($sformatf("v%0d_result", i), r, vecs[i].res);
      chk($sformatf("v%0d_flags", i), f, vecs[i].flg);
      chk($sformatf("v%0d_in_ready_after", i), in_ready, 1);
      chk($sformatf("v%0d_alu_sel_hold", i), alu_sel, {5'b0, vecs[i].op[2:0]});
      chk($sformatf("v%0d_alu_a_hold", i), alu_a, vecs[i].a);
      chk($sformatf("v%0d_alu_b_hold", i), alu_b, vecs[i].b);
    end

    // Illegal opcodes, including a back-to-back pair.
    send_byte(8'h09);
    chk("ill_err_pulse", err, 1);
    chk("ill_busy", busy, 0);
    chk("ill_sel_hold", alu_sel, 3'd7);
    send_byte(8'hFF);
    chk("ill_err_b2b", err, 1);
    @(negedge clk);
    chk("ill_err_end", err, 0);
    chk("ill_no_out", out_valid, 0);
    send_frame(8'h00, 8'h01, 8'h01, 0);
    recv(r, f);
    chk("post_ill_result", r, 8'h02);
    chk("post_ill_flags", f, 8'h00);

    // Output backpressure while bytes are offered upstream.
    out_ready = 1'b0;
    send_frame(8'h03, 8'hA0, 8'h05, 0);
    wait_out(lat);
    in_data  = 8'h02;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", k), out_valid, 1);
      chk($sformatf("bp_data_%0d", k), out_data, 8'hA5);
      chk($sformatf("bp_in_ready_%0d", k), in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    recv(r, f);
    chk("bp_result", r, 8'hA5);
    chk("bp_flags", f, 8'h00);
    chk("bp_sel_not_consumed", alu_sel, 3'd3);

    // Reset pulse between edges after the A byte.
    send_byte(8'h00);
    send_byte(8'h11);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_sel", alu_sel, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    send_frame(8'h00, 8'h01, 8'h01, 0);
    recv(r, f);
    chk("after_rst_result", r, 8'h02);
    chk("after_rst_flags", f, 8'h00);

    // Reset while a result is waiting drops out_valid immediately.
    out_ready = 1'b0;
    send_frame(8'h03, 8'h0F, 8'h30, 0);
    wait_out(lat);
    chk("hold_before_rst", out_data, 8'h3F);
    #1 rst = 1'b1;
    #1;
    chk("rst_drop_valid", out_valid, 0);
    chk("rst_drop_data", out_data, 0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Long settle instance: 0xFF + 0x01 wraps to zero with carry.
    in_data = 8'h00; in_valid15 = 1'b1;
    @(negedge clk);
    chk("s15_busy_a", busy15, 1);
    in_data = 8'hFF;
    @(negedge clk);
    in_data = 8'h01;
    @(negedge clk);
    in_valid15 = 1'b0;
    chk("s15_in_ready_exec", in_ready15, 0);
    lat = 1;
    while (!out_valid15 && lat <= 40) begin
      @(negedge clk);
      lat++;
    end
    chk("s15_latency", lat, 16);
    r = out_data15;
    @(negedge clk);
    f = out_data15;
    chk("s15_result", r, 8'h00);
    chk("s15_flags", f, 8'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Byte-stream command front end for the 8-bit ALU. It accepts a three-byte frame (opcode, operand A, operand B) over a valid/ready input channel and drives the ALU operand and select pins. After a fixed settle time it captures the ALU result and carry, then returns a result byte and a flags byte over a valid/ready output channel. It is the initiator side of the ALU interface and sits between the chip I/O pins and the ALU.

## Interface

Parameters:

- SETTLE_CYCLES, default 1: number of cycles the ALU outputs settle before capture; legal range 1..15.

Ports:

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  frame byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a byte this cycle.
- alu_a  out  8  ALU operand A.
- alu_b  out  8  ALU operand B.
- alu_sel  out  3  ALU operation select.
- alu_result  in  8  ALU result.
- alu_cout  in  1  ALU carry out.
- out_data  out  8  result byte, then flags byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high whenever state is not S_OP.
- err  out  1  one-cycle pulse on an illegal opcode.

## Operation

- **Handshake rule:** a transfer occurs on a rising edge where valid and ready are both high. Both channels carry at most one byte per cycle.
- **States:** S_OP, S_A, S_B, S_EXEC, S_RES, S_FLG.
- **S_OP:** in_ready=1.
  - On handshake with in_data[7:3]==0: alu_sel<=in_data[2:0], go to S_A.
  - On handshake with in_data[7:3]!=0: err=1 for the next cycle, alu_sel unchanged, stay in S_OP. The byte is consumed and the frame is dropped.
- **S_A:** in_ready=1. On handshake: alu_a<=in_data, go to S_B.
- **S_B:** in_ready=1. On handshake: alu_b<=in_data, load settle counter with SETTLE_CYCLES, go to S_EXEC.
- **S_EXEC:** in_ready=0. The counter decrements each cycle. On the edge where the counter reaches 1: res_q<=alu_result, cout_q<=alu_cout, zero_q<=(alu_result==0), go to S_RES.
- **S_RES:** out_valid=1, out_data=res_q. On handshake, go to S_FLG.
- **S_FLG:** out_valid=1, out_data={6'b0, zero_q, cout_q}. On handshake, go to S_OP.
- **Select codes:** sel values 4..7 are legal and forwarded unchanged. The ALU returns 0 for them, so the flags byte is 0x02.
- **Operand hold:** alu_a, alu_b and alu_sel hold their last loaded value between frames; only a handshake updates them.
- **Output stability:** while out_valid=1 and out_ready=0, out_data must not change.
- **Flags:** all arithmetic is the ALU's; this block only registers values. The zero flag is computed on the 8-bit captured result.

## Timing

- **Reset values:** in_ready=1, out_valid=0, out_data=0, alu_a=0, alu_b=0, alu_sel=0, busy=0, err=0, state S_OP, counter 0, res_q/cout_q/zero_q=0.
- **Async reset:** takes effect immediately, without a clock edge. If asserted mid-frame, the partial frame is discarded and out_valid drops at once. The first frame after deassertion starts with the opcode byte.
- **Input cadence:** with in_valid held high, the opcode, A and B bytes are accepted on three consecutive edges.
- **Latency:** from the B handshake edge to out_valid=1 is SETTLE_CYCLES+1 cycles. With SETTLE_CYCLES=1, B is accepted at edge n, S_EXEC occupies cycle n+1, capture happens at edge n+1, and out_valid is high from n+2.
- **Output cadence:** with out_ready held high, the result and flags bytes go out on consecutive edges. in_ready returns to 1 in the cycle after the flags handshake.
- **Minimum frame period:** 3 + SETTLE_CYCLES + 2 cycles.
- **Backpressure:** in_ready is low from S_EXEC through S_FLG. Bytes offered then are not consumed and remain the upstream's responsibility.
- **err:** asserted for exactly one cycle, starting the cycle after the illegal opcode handshake. Back-to-back illegal opcodes give back-to-back pulses.

## Test plan

- **Add with carry:** frame 0x00, 0xC8, 0x64 with SETTLE_CYCLES=1 and a real ALU attached -> out bytes 0x2C then 0x01. out_valid rises exactly 2 cycles after the B handshake.
- **Subtract wrap:** frame 0x01, 0x05, 0x07 -> 0xFE, 0x00. AND to zero: frame 0x02, 0xF0, 0x0F -> 0x00, 0x02. OR: frame 0x03, 0xA0, 0x05 -> 0xA5, 0x00.
- **Illegal opcode:** send 0x09 -> single err pulse, no out_valid, busy stays 0. The following frame 0x00, 0x01, 0x01 -> 0x02, 0x00.
- **Backpressure and input gaps:** out_ready held low for 5 cycles in S_RES -> out_valid stays high, out_data stable at the result, in_ready=0, no new bytes consumed. Random in_valid gaps give identical results.
- **Reset mid-frame:** rst pulsed after the A byte (including a pulse between clock edges) -> all outputs at reset values immediately. A new full frame then completes correctly.
- **Parameter sweep:** SETTLE_CYCLES=15 -> the B-handshake-to-out_valid latency is 16 cycles, and the result is correct.
